red_blob_tracker: RTL

Streaming pixel-pipeline stage for the rover vision path: horizontal box blur over a parametrised tap count, per-pixel red-colour classification, and per-frame bounding-box accumulation of detected pixels. It sits between the video packet source and the display/overlay output. It uses a valid/ready handshake with back-pressure. It reports one bounding-box result per frame to the navigation logic.

---
 rtl/vision_pkg.sv | 36 +++
 rtl/box_blur_line.sv | 47 ++++
 rtl/red_blob_tracker.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vision_pkg.sv
// Shared pixel/bbox types and helpers for the rover vision path.
// Optional feature macro used by red_blob_tracker: BBOX_OVERLAY_EN.
package vision_pkg;

    localparam int PIX_W   = 8;
    localparam int BBOX_XW = 10;
    localparam int BBOX_YW = 9;
    localparam int BBOX_CW = 20;

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } rgb_t;

    typedef struct packed {
        logic               found;
        logic [BBOX_XW-1:0] x_min;
        logic [BBOX_XW-1:0] x_max;
        logic [BBOX_YW-1:0] y_min;
        logic [BBOX_YW-1:0] y_max;
        logic [BBOX_CW-1:0] count;
    } bbox_t;

    function automatic int coord_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Luma-ish grey: g/2 + r/4 + b/4, never exceeds the channel range.
    function automatic logic [15:0] grey(input logic [15:0] r,
                                         input logic [15:0] g,
                                         input logic [15:0] b);
        return (g >> 1) + (r >> 2) + (b >> 2);
    endfunction

endpackage

// File: rtl/box_blur_line.sv
// One colour channel of the horizontal box blur: TAPS-wide window
// including the current pixel, replicated from the first pixel of each line.
module box_blur_line #(
    parameter int DATA_W = 8,
    parameter int TAPS   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_first,
    input  logic [DATA_W-1:0] i_pix,
    output logic [DATA_W-1:0] o_blur
);

    localparam int LG = $clog2(TAPS);
    localparam int SW = DATA_W + LG;

    logic [DATA_W-1:0] r_hist [0:TAPS-2];
    logic [SW-1:0]     w_sum;

    always_comb begin
        w_sum = SW'(i_pix);
        if (i_first) begin
            w_sum = SW'(i_pix) << LG;
        end else begin
            for (int i = 0; i < TAPS-1; i++) begin
                w_sum = w_sum + SW'(r_hist[i]);
            end
        end
    end

    assign o_blur = DATA_W'(w_sum >> LG);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS-1; i++) begin
                r_hist[i] <= '0;
            end
        end else if (i_en) begin
            r_hist[0] <= i_pix;
            for (int i = 1; i < TAPS-1; i++) begin
                r_hist[i] <= i_first ? i_pix : r_hist[i-1];
            end
        end
    end

endmodule

// File: rtl/red_blob_tracker.sv
// Blur -> red classify -> per-frame bounding box, two-stage stream pipeline.
// Optional: `define BBOX_OVERLAY_EN draws the previous frame's box in green.
module red_blob_tracker
    import vision_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int TAPS    = 4,
    parameter int IMAGE_W = 640,
    parameter int IMAGE_H = 480,
    parameter int THRESH  = 40,
    parameter int MIN_VAL = 20,
    parameter int CNT_W   = 20
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_sop,
    input  logic                         in_eop,
    input  logic [DATA_W-1:0]            in_r,
    input  logic [DATA_W-1:0]            in_g,
    input  logic [DATA_W-1:0]            in_b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_sop,
    output logic                         out_eop,
    output logic [DATA_W-1:0]            out_r,
    output logic [DATA_W-1:0]            out_g,
    output logic [DATA_W-1:0]            out_b,
    output logic                         out_detect,
    output logic                         bbox_valid,
    output logic                         bbox_found,
    output logic [coord_w(IMAGE_W)-1:0]  bbox_x_min,
    output logic [coord_w(IMAGE_W)-1:0]  bbox_x_max,
    output logic [coord_w(IMAGE_H)-1:0]  bbox_y_min,
    output logic [coord_w(IMAGE_H)-1:0]  bbox_y_max,
    output logic [CNT_W-1:0]             bbox_count
);

    localparam int XW = coord_w(IMAGE_W);
    localparam int YW = coord_w(IMAGE_H);
    localparam int CW = DATA_W + 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMAGE_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_H - 1);
    localparam logic [CW-1:0] TH     = CW'(THRESH);
    localparam logic [CW-1:0] MV     = CW'(MIN_VAL);

    logic          w_adv;
    logic          w_live;
    logic          w_take;
    logic          w_first;
    logic [XW-1:0] w_x;
    logic [YW-1:0] w_y;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_seen;

    assign in_ready = out_ready || !out_valid;
    assign w_adv    = in_ready;
    assign w_live   = in_valid && (in_sop || r_seen);
    assign w_take   = w_adv && w_live;
    assign w_x      = in_sop ? '0 : r_x;
    assign w_y      = in_sop ? '0 : r_y;
    assign w_first  = (w_x == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_seen <= 1'b0;
        end else if (w_adv && in_valid) begin
            if (in_sop) begin
                r_seen <= 1'b1;
            end
            if (w_x == X_LAST) begin
                r_x <= '0;
                r_y <= (w_y == Y_LAST) ? w_y : w_y + YW'(1);
            end else begin
                r_x <= w_x + XW'(1);
                r_y <= w_y;
            end
        end
    end

    logic [DATA_W-1:0] w_br;
    logic [DATA_W-1:0] w_bg;
    logic [DATA_W-1:0] w_bb;

    box_blur_line #(.DATA_W(DATA_W), .TAPS(TAPS)) u_blur_r (
        .clk(clk), .rst_n(rst_n), .i_en(w_take), .i_first(w_first),
        .i_pix(in_r), .o_blur(w_br)
    );
    box_blur_line #(.DATA_W(DATA_W), .TAPS(TAPS)) u_blur_g (
        .clk(clk), .rst_n(rst_n), .i_en(w_take), .i_first(w_first),
        .i_pix(in_g), .o_blur(w_bg)
    );
    box_blur_line #(.DATA_W(DATA_W), .TAPS(TAPS)) u_blur_b (
        .clk(clk), .rst_n(rst_n), .i_en(w_take), .i_first(w_first),
        .i_pix(in_b), .o_blur(w_bb)
    );

    // S1: blurred pixel register
    logic              r_s1_valid;
    logic              r_s1_sop;
    logic              r_s1_eop;
    logic [XW-1:0]     r_s1_x;
    logic [YW-1:0]     r_s1_y;
    logic [DATA_W-1:0] r_s1_r;
    logic [DATA_W-1:0] r_s1_g;
    logic [DATA_W-1:0] r_s1_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sop   <= 1'b0;
            r_s1_eop   <= 1'b0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
            r_s1_r     <= '0;
            r_s1_g     <= '0;
            r_s1_b     <= '0;
        end else if (w_adv) begin
            r_s1_valid <= w_live;
            r_s1_sop   <= w_live && in_sop;
            r_s1_eop   <= w_live && in_eop;
            r_s1_x     <= w_x;
            r_s1_y     <= w_y;
            r_s1_r     <= w_br;
            r_s1_g     <= w_bg;
            r_s1_b     <= w_bb;
        end
    end

    logic              w_det;
    logic [DATA_W-1:0] w_grey;
    logic [DATA_W-1:0] w_or;
    logic [DATA_W-1:0] w_og;
    logic [DATA_W-1:0] w_ob;

    assign w_det = ({1'b0, r_s1_r} > {1'b0, r_s1_g} + TH) &&
                   ({1'b0, r_s1_r} > {1'b0, r_s1_b} + TH) &&
                   ({1'b0, r_s1_r} >= MV);
    assign w_grey = DATA_W'(grey(16'(r_s1_r), 16'(r_s1_g), 16'(r_s1_b)));

`ifdef BBOX_OVERLAY_EN
    logic w_in_x;
    logic w_in_y;
    logic w_edge;

    assign w_in_x = (r_s1_x >= bbox_x_min) && (r_s1_x <= bbox_x_max);
    assign w_in_y = (r_s1_y >= bbox_y_min) && (r_s1_y <= bbox_y_max);
    assign w_edge = bbox_found &&
        ((((r_s1_x == bbox_x_min) || (r_s1_x == bbox_x_max)) && w_in_y) ||
         (((r_s1_y == bbox_y_min) || (r_s1_y == bbox_y_max)) && w_in_x));
`endif

    always_comb begin
        w_or = w_det ? r_s1_r : w_grey;
        w_og = w_det ? r_s1_g : w_grey;
        w_ob = w_det ? r_s1_b : w_grey;
`ifdef BBOX_OVERLAY_EN
        if (w_edge) begin
            w_or = '0;
            w_og = '1;
            w_ob = '0;
        end
`endif
    end

    // S2: output register
    logic [XW-1:0] r_s2_x;
    logic [YW-1:0] r_s2_y;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            out_r      <= '0;
            out_g      <= '0;
            out_b      <= '0;
            out_detect <= 1'b0;
            r_s2_x     <= '0;
            r_s2_y     <= '0;
        end else if (w_adv) begin
            out_valid  <= r_s1_valid;
            out_sop    <= r_s1_sop;
            out_eop    <= r_s1_eop;
            out_r      <= w_or;
            out_g      <= w_og;
            out_b      <= w_ob;
            out_detect <= w_det;
            r_s2_x     <= r_s1_x;
            r_s2_y     <= r_s1_y;
        end
    end

    // An sop beat starts from an empty box, which also drops an aborted frame.
    logic             w_xfer;
    logic [XW-1:0]    r_xmin;
    logic [XW-1:0]    r_xmax;
    logic [YW-1:0]    r_ymin;
    logic [YW-1:0]    r_ymax;
    logic [CNT_W-1:0] r_cnt;
    logic [XW-1:0]    w_xmin;
    logic [XW-1:0]    w_xmax;
    logic [YW-1:0]    w_ymin;
    logic [YW-1:0]    w_ymax;
    logic [CNT_W-1:0] w_cnt;
    logic             w_found;

    assign w_xfer = out_valid && out_ready;

    always_comb begin
        w_xmin = out_sop ? X_LAST : r_xmin;
        w_xmax = out_sop ? '0     : r_xmax;
        w_ymin = out_sop ? Y_LAST : r_ymin;
        w_ymax = out_sop ? '0     : r_ymax;
        w_cnt  = out_sop ? '0     : r_cnt;
        if (out_detect) begin
            if (r_s2_x < w_xmin) w_xmin = r_s2_x;
            if (r_s2_x > w_xmax) w_xmax = r_s2_x;
            if (r_s2_y < w_ymin) w_ymin = r_s2_y;
            if (r_s2_y > w_ymax) w_ymax = r_s2_y;
            if (w_cnt != '1) w_cnt = w_cnt + CNT_W'(1);
        end
    end

    assign w_found = (w_cnt != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_xmin     <= X_LAST;
            r_xmax     <= '0;
            r_ymin     <= Y_LAST;
            r_ymax     <= '0;
            r_cnt      <= '0;
            bbox_valid <= 1'b0;
            bbox_found <= 1'b0;
            bbox_x_min <= '0;
            bbox_x_max <= '0;
            bbox_y_min <= '0;
            bbox_y_max <= '0;
            bbox_count <= '0;
        end else begin
            bbox_valid <= w_xfer && out_eop;
            if (w_xfer && out_eop) begin
                bbox_found <= w_found;
                bbox_x_min <= w_found ? w_xmin : '0;
                bbox_x_max <= w_found ? w_xmax : '0;
                bbox_y_min <= w_found ? w_ymin : '0;
                bbox_y_max <= w_found ? w_ymax : '0;
                bbox_count <= w_cnt;
                r_xmin     <= X_LAST;
                r_xmax     <= '0;
                r_ymin     <= Y_LAST;
                r_ymax     <= '0;
                r_cnt      <= '0;
            end else if (w_xfer) begin
                r_xmin <= w_xmin;
                r_xmax <= w_xmax;
                r_ymin <= w_ymin;
                r_ymax <= w_ymax;
                r_cnt  <= w_cnt;
            end
        end
    end

endmodule
